// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: KMP-style prefix FSM, overlap/non-overlap, saturating hit counter.
// Latency: Mealy z in the same cycle as the completing bit, Moore z one cycle later; no backpressure (en qualifies each bit).
module seq_detect_fsm #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter bit                   MOORE     = 1'b0,
  parameter int                   CNT_W     = 8,
  parameter int                   SW        = $clog2(PATTERN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             cnt_clr,
  output logic [SW-1:0]    pres_st,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  // Bit idx of PATTERN, counted from the LSB; shifting avoids wide index expressions.
  function automatic bit pbit(input int idx);
    logic [PATTERN_W-1:0] t;
    t = PATTERN >> idx;
    return t[0];
  endfunction

  // Longest proper pattern prefix that is a suffix of (first s pattern bits, then bit b).
  function automatic int prefix_after(input int s, input int b);
    int best;
    best = 0;
    for (int k = 1; k <= s + 1; k++) begin
      if (k < PATTERN_W) begin
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          int j;
          bit sb;
          j  = s + 1 - k + i;
          sb = (j == s) ? b[0] : pbit(PATTERN_W - 1 - j);
          if (sb != pbit(PATTERN_W - 1 - i)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the whole pattern that is also its suffix.
  function automatic int restart_state();
    int best;
    best = 0;
    for (int k = 1; k < PATTERN_W; k++) begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pbit(PATTERN_W - 1 - i) != pbit(k - 1 - i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam logic [SW-1:0] LAST_ST    = SW'(PATTERN_W - 1);
  localparam logic [SW-1:0] RESTART_ST = OVERLAP ? SW'(restart_state()) : '0;

  logic [SW-1:0] nxt_tbl [PATTERN_W][2];

  for (genvar gs = 0; gs < PATTERN_W; gs++) begin : g_tbl
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int NXT = prefix_after(gs, gb);
      assign nxt_tbl[gs][gb] = SW'(NXT);
    end
  end

  logic             hit;
  logic             z_q;
  logic [SW-1:0]    st_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // A bit presented together with rst never counts as a hit.
  assign hit = en & ~rst & (pres_st == LAST_ST) & (a == PATTERN[0]);
  assign z   = MOORE ? z_q : hit;

  always_comb begin
    st_nxt  = pres_st;
    cnt_nxt = match_cnt;
    if (en) begin
      st_nxt = hit ? RESTART_ST : nxt_tbl[pres_st][a];
    end
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      cnt_nxt = match_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pres_st   <= '0;
      match_cnt <= '0;
      z_q       <= 1'b0;
    end else begin
      pres_st   <= st_nxt;
      match_cnt <= cnt_nxt;
      z_q       <= hit;
    end
  end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: six parameterisations share one input stream, table rows pick the DUT checked.
module tb_seq_detect_fsm;

  localparam int OV = 0, NO = 1, P2 = 2, MO = 3, C2 = 4, P11 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, a = 1'b0, cnt_clr = 1'b0;

  logic [1:0] st_ov, st_no, st_p2, st_mo, st_c2;
  logic [0:0] st_p11;
  logic       z_ov, z_no, z_p2, z_mo, z_c2, z_p11;
  logic [7:0] cnt_ov, cnt_no, cnt_p2, cnt_mo, cnt_p11;
  logic [1:0] cnt_c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_ov), .z(z_ov), .match_cnt(cnt_ov));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_no), .z(z_no), .match_cnt(cnt_no));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_p2), .z(z_p2), .match_cnt(cnt_p2));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u_mo (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_mo), .z(z_mo), .match_cnt(cnt_mo));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_c2), .z(z_c2), .match_cnt(cnt_c2));
  seq_detect_fsm #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_p11 (
    .clk(clk), .rst(rst), .en(en), .a(a), .cnt_clr(cnt_clr), .pres_st(st_p11), .z(z_p11), .match_cnt(cnt_p11));

  typedef struct {
    int   sel;
    logic rst, en, a, clr;
    int   ez, est, ecnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int sel, input logic r, input logic e, input logic b, input logic c,
                     input int ez, input int est, input int ecnt);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.a = b; v.clr = c;
    v.ez = ez; v.est = est; v.ecnt = ecnt;
    vt.push_back(v);
  endtask

  task automatic sample(input int sel, output int st, output int zz, output int cnt);
    case (sel)
      OV:      begin st = int'(st_ov);  zz = int'(z_ov);  cnt = int'(cnt_ov);  end
      NO:      begin st = int'(st_no);  zz = int'(z_no);  cnt = int'(cnt_no);  end
      P2:      begin st = int'(st_p2);  zz = int'(z_p2);  cnt = int'(cnt_p2);  end
      MO:      begin st = int'(st_mo);  zz = int'(z_mo);  cnt = int'(cnt_mo);  end
      C2:      begin st = int'(st_c2);  zz = int'(z_c2);  cnt = int'(cnt_c2);  end
      default: begin st = int'(st_p11); zz = int'(z_p11); cnt = int'(cnt_p11); end
    endcase
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  // Drive at the falling edge, sample Mealy z before the rising edge and state/count/Moore z just after it.
  task automatic apply(input int row, input vec_t v);
    int st, zpre, zpost, cnt;
    rst = v.rst; en = v.en; a = v.a; cnt_clr = v.clr;
    #2;
    sample(v.sel, st, zpre, cnt);
    @(posedge clk);
    #1;
    sample(v.sel, st, zpost, cnt);
    chk("z", row, (v.sel == MO) ? zpost : zpre, v.ez);
    chk("pres_st", row, st, v.est);
    chk("match_cnt", row, cnt, v.ecnt);
    @(negedge clk);
  endtask

  initial begin
    vec_t hv;

    // Pattern 1011, overlapping, Mealy
    add(OV, 1,0,0,0, 0,0,0);
    add(OV, 0,1,1,0, 0,1,0); add(OV, 0,1,0,0, 0,2,0); add(OV, 0,1,1,0, 0,3,0);
    add(OV, 0,1,1,0, 1,1,1); add(OV, 0,1,0,0, 0,2,1); add(OV, 0,1,1,0, 0,3,1);
    add(OV, 0,1,1,0, 1,1,2);
    // Same stream, non-overlapping
    add(NO, 1,0,0,0, 0,0,0);
    add(NO, 0,1,1,0, 0,1,0); add(NO, 0,1,0,0, 0,2,0); add(NO, 0,1,1,0, 0,3,0);
    add(NO, 0,1,1,0, 1,0,1); add(NO, 0,1,0,0, 0,0,1); add(NO, 0,1,1,0, 0,1,1);
    add(NO, 0,1,1,0, 0,1,1);
    // Pattern 1101: third 1 keeps the prefix length at 2
    add(P2, 1,0,0,0, 0,0,0);
    add(P2, 0,1,1,0, 0,1,0); add(P2, 0,1,1,0, 0,2,0); add(P2, 0,1,1,0, 0,2,0);
    add(P2, 0,1,0,0, 0,3,0); add(P2, 0,1,1,0, 1,1,1);
    // Moore with en=0 gaps, including a=1 held while disabled in the last state
    add(MO, 1,0,0,0, 0,0,0);
    add(MO, 0,1,1,0, 0,1,0); add(MO, 0,0,0,0, 0,1,0); add(MO, 0,1,0,0, 0,2,0);
    add(MO, 0,1,1,0, 0,3,0); add(MO, 0,0,1,0, 0,3,0); add(MO, 0,0,1,0, 0,3,0);
    add(MO, 0,1,1,0, 1,1,1); add(MO, 0,1,0,0, 0,2,1); add(MO, 0,1,1,0, 0,3,1);
    add(MO, 0,0,0,0, 0,3,1); add(MO, 0,1,1,0, 1,1,2);
    // 2-bit counter saturation, then clear coincident with a hit
    add(C2, 1,0,0,0, 0,0,0);
    add(C2, 0,1,1,0, 0,1,0); add(C2, 0,1,0,0, 0,2,0); add(C2, 0,1,1,0, 0,3,0);
    add(C2, 0,1,1,0, 1,1,1);
    for (int h = 2; h <= 5; h++) begin
      add(C2, 0,1,0,0, 0,2,(h > 4) ? 3 : h - 1);
      add(C2, 0,1,1,0, 0,3,(h > 4) ? 3 : h - 1);
      add(C2, 0,1,1,0, 1,1,(h > 3) ? 3 : h);
    end
    add(C2, 0,1,0,0, 0,2,3); add(C2, 0,1,1,0, 0,3,3); add(C2, 0,1,1,1, 1,1,0);
    add(C2, 0,1,0,0, 0,2,0); add(C2, 0,1,1,0, 0,3,0); add(C2, 0,1,1,0, 1,1,1);
    add(C2, 0,0,0,1, 0,1,0);
    // Reset mid-pattern with the completing bit presented
    add(OV, 1,0,0,0, 0,0,0);
    add(OV, 0,1,1,0, 0,1,0); add(OV, 0,1,0,0, 0,2,0); add(OV, 0,1,1,0, 0,3,0);
    add(OV, 0,1,1,0, 1,1,1); add(OV, 0,1,0,0, 0,2,1); add(OV, 0,1,1,0, 0,3,1);
    add(OV, 1,1,1,0, 0,0,0);
    add(OV, 0,1,1,0, 0,1,0); add(OV, 0,1,0,0, 0,2,0); add(OV, 0,1,1,0, 0,3,0);
    add(OV, 0,1,1,0, 1,1,1);
    // Pattern 11: back-to-back hits give multi-cycle z
    add(P11, 1,0,0,0, 0,0,0);
    add(P11, 0,1,1,0, 0,1,0); add(P11, 0,1,1,0, 1,1,1); add(P11, 0,1,1,0, 1,1,2);
    add(P11, 0,1,0,0, 0,0,2); add(P11, 0,1,1,0, 0,1,2); add(P11, 0,1,1,0, 1,1,3);

    for (int i = 0; i < vt.size(); i++) apply(i, vt[i]);

    // Hand sequence: Mealy z follows en/a combinationally; Moore z lags by one edge.
    hv.sel = OV; hv.clr = 1'b0;
    hv.rst = 1'b1; hv.en = 1'b0; hv.a = 1'b0; hv.ez = 0; hv.est = 0; hv.ecnt = 0; apply(900, hv);
    hv.rst = 1'b0; hv.en = 1'b1; hv.a = 1'b1; hv.est = 1; apply(901, hv);
    hv.a = 1'b0; hv.est = 2; apply(902, hv);
    hv.a = 1'b1; hv.est = 3; apply(903, hv);
    en = 1'b0; a = 1'b1; #1;
    chk("mealy_z_en_low", 904, int'(z_ov), 0);
    en = 1'b1; #1;
    chk("mealy_z_comb", 905, int'(z_ov), 1);
    chk("moore_z_before_edge", 906, int'(z_mo), 0);
    a = 1'b0; #1;
    chk("mealy_z_a_low", 907, int'(z_ov), 0);
    a = 1'b1; cnt_clr = 1'b1; #1;
    chk("mealy_z_with_clr", 908, int'(z_ov), 1);
    @(posedge clk); #1;
    chk("clr_beats_hit_cnt", 909, int'(cnt_ov), 0);
    chk("clr_hit_state", 910, int'(st_ov), 1);
    chk("moore_z_after_edge", 911, int'(z_mo), 1);
    @(negedge clk);
    en = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    chk("moore_z_one_cycle", 912, int'(z_mo), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
